fetch_pc_btb: RTL and testbench
===============================

FETCH_PC_BTB -- requirements
Module: fetch_pc_btb

Interface
REQ-001 Parameter BTB_ENTRIES, default 16, number of direct-mapped BTB entries, power of two, 4..64.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 stall  in  1  hold the fetch PC (downstream hazard).
REQ-006 redirect_valid  in  1  EX-stage mispredict; load redirect_pc.
REQ-007 redirect_pc  in  32  corrected fetch address.
REQ-008 upd_valid  in  1  a resolved branch/jump is reported this cycle.
REQ-009 upd_pc  in  32  address of the resolved branch.
REQ-010 upd_taken  in  1  resolved outcome.
REQ-011 upd_target  in  32  resolved taken target.
REQ-012 pc  out  32  current fetch address, drives the instruction memory word index pc[11:2].
REQ-013 pred_taken  out  1  current pc hits the BTB and its counter is >= 2.
REQ-014 pred_target  out  32  BTB target for current pc; 0 when no hit.
REQ-015 stat_hits  out  32  BTB hit count (see Configuration).
REQ-016 stat_redirects  out  32  redirect count (see Configuration).

Function
REQ-017 Index = pc[log2(BTB_ENTRIES)+1:2]; tag = remaining upper bits above the index; pc[1:0] is ignored.
REQ-018 Entry = valid, tag, 32-bit target, 2-bit saturating counter (0 SNT, 1 WNT, 2 WT, 3 ST).
REQ-019 Lookup is combinational on the registered pc; pred_taken/pred_target are valid in the same cycle as pc.
REQ-020 Next-pc priority: redirect_valid -> redirect_pc; else stall -> pc unchanged; else pred_taken -> pred_target; else pc+4 (mod 2^32 wrap).
REQ-021 redirect_valid overrides stall in the same cycle.
REQ-022 Update on upd_valid at the rising edge, indexed by upd_pc: on hit, counter increments on taken (saturates at 3) or decrements on not-taken (saturates at 0); target is rewritten with upd_target when taken.
REQ-023 Update miss with upd_taken=1: allocate the entry (overwriting any occupant), valid=1, new tag, target=upd_target, counter=2.
REQ-024 Update miss with upd_taken=0: BTB unchanged.
REQ-025 Update is independent of stall and redirect_valid.
REQ-026 A lookup and an update to the same index in one cycle: the lookup sees pre-update contents; the new contents are visible from the next cycle.
REQ-027 pc+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.

Reset
REQ-028 While rst=1 at an edge: pc=RESET_PC, every valid bit cleared, stat counters cleared; counters/targets/tags need not be cleared.
REQ-029 rst has priority over redirect, stall and update; an update presented in a reset cycle is discarded.
REQ-030 In the first cycle after reset, pred_taken=0 and pred_target=0.

Configuration
REQ-031 Macro BTB_STATS_EN defined: stat_hits increments on each non-stalled cycle with a BTB hit; stat_redirects increments on each redirect_valid cycle; both wrap at 2^32.
REQ-032 Macro BTB_STATS_EN undefined: both stat ports are constant 0, no counter registers exist, and all other behaviour is identical.

Verification
REQ-033 Reset, no stall, 4 cycles -> pc 0,4,8,12; pred_taken=0 throughout.
REQ-034 Update pc=0x10 taken, target=0x40; refetch 0x10 -> pred_taken=1, pred_target=0x40, next pc=0x40.
REQ-035 Entry 0x10 at counter 2; two not-taken updates -> counter 0, pred_taken=0 at 0x10, next pc 0x14; one taken update -> counter 1, still not predicted.
REQ-036 stall=1 and redirect_valid=1 with redirect_pc=0x200 in the same cycle -> pc=0x200 next cycle; stat_redirects +1 with BTB_STATS_EN.
REQ-037 With BTB_ENTRIES=16, entry 0x10 allocated; taken update at 0x50 (same index, different tag) -> 0x10 misses, 0x50 hits with its own target.
REQ-038 Assert rst mid-run with pc=0x80 and BTB populated -> pc=RESET_PC, no hits until a new allocation, stat counters 0.

Source files
------------

// File: rtl/fetch_pc_btb.sv
// Fetch PC register with a direct-mapped branch target buffer.
// Each entry holds valid, tag, target and a 2-bit saturating counter.
// The prediction is looked up combinationally from the registered pc.
// Optional feature macro: BTB_STATS_EN adds wrapping hit and redirect counters.
// Without the macro both stat ports read constant 0.
module fetch_pc_btb #(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_redirects
);

    localparam int unsigned IdxW = $clog2(BTB_ENTRIES);
    localparam int unsigned TagW = 30 - IdxW;

    logic [31:0]            pc_q, pc_d;
    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [TagW-1:0]        tag_q    [BTB_ENTRIES];
    logic [TagW-1:0]        tag_d    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];
    logic [31:0]            target_d [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];
    logic [1:0]             ctr_d    [BTB_ENTRIES];

    logic [IdxW-1:0] rd_idx;
    logic [TagW-1:0] rd_tag;
    logic            rd_hit;
    logic [IdxW-1:0] wr_idx;
    logic [TagW-1:0] wr_tag;
    logic            wr_hit;

    assign rd_idx = pc_q[IdxW+1:2];
    assign rd_tag = pc_q[31:IdxW+2];
    assign wr_idx = upd_pc[IdxW+1:2];
    assign wr_tag = upd_pc[31:IdxW+2];

    // Lookup on the registered pc; sees pre-update contents.
    always_comb begin
        rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        pred_taken  = rd_hit && ctr_q[rd_idx][1];
        pred_target = rd_hit ? target_q[rd_idx] : 32'h0;
    end

    // Next fetch address: redirect beats stall, stall beats prediction.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // BTB training: counter update on hit, allocation only on a taken miss.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_valid) begin
            if (wr_hit) begin
                if (upd_taken) begin
                    if (ctr_q[wr_idx] != 2'd3) begin
                        ctr_d[wr_idx] = ctr_q[wr_idx] + 2'd1;
                    end
                    target_d[wr_idx] = upd_target;
                end else if (ctr_q[wr_idx] != 2'd0) begin
                    ctr_d[wr_idx] = ctr_q[wr_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[wr_idx]  = 1'b1;
                tag_d[wr_idx]    = wr_tag;
                target_d[wr_idx] = upd_target;
                ctr_d[wr_idx]    = 2'd2;
            end
        end
    end

    // PC and valid bits are reset; a reset cycle discards any update.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload needs no reset since valid gates every use of it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

    assign pc = pc_q;

`ifdef BTB_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_redirects_q, stat_redirects_d;

    // Hits count only on cycles where fetch advances; both counters wrap.
    always_comb begin
        stat_hits_d      = stat_hits_q;
        stat_redirects_d = stat_redirects_q;
        if (rd_hit && !stall) begin
            stat_hits_d = stat_hits_q + 32'd1;
        end
        if (redirect_valid) begin
            stat_redirects_d = stat_redirects_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q      <= 32'h0;
            stat_redirects_q <= 32'h0;
        end else begin
            stat_hits_q      <= stat_hits_d;
            stat_redirects_q <= stat_redirects_d;
        end
    end

    assign stat_hits      = stat_hits_q;
    assign stat_redirects = stat_redirects_q;
`else
    assign stat_hits      = 32'h0;
    assign stat_redirects = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_pc_btb.sv
// Self-checking bench for fetch_pc_btb: directed scenarios then random traffic,
// all compared against a behavioural BTB model held in plain arrays.
module tb_fetch_pc_btb;

    localparam int unsigned Entries = 16;
    localparam int unsigned IdxBits = $clog2(Entries);
    localparam logic [31:0] ResetPc = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] stat_hits;
    logic [31:0] stat_redirects;

    fetch_pc_btb #(
        .BTB_ENTRIES(Entries),
        .RESET_PC   (ResetPc)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .pc            (pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .stat_hits     (stat_hits),
        .stat_redirects(stat_redirects)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_pc;
    bit          m_valid  [Entries];
    logic [31:0] m_tag    [Entries];
    logic [31:0] m_target [Entries];
    int          m_ctr    [Entries];
    logic [31:0] m_hits;
    logic [31:0] m_redirs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) % Entries);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] a);
        return a >> (IdxBits + 2);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
    endfunction

    function automatic bit m_pred(input logic [31:0] a);
        return m_hit(a) && (m_ctr[m_idx(a)] >= 2);
    endfunction

    task automatic compare_all();
        logic [31:0] exp_tgt;
        exp_tgt = m_hit(m_pc) ? m_target[m_idx(m_pc)] : 32'h0;
        check_eq("pc", pc, m_pc);
        check_eq("pred_taken", {31'h0, pred_taken}, {31'h0, m_pred(m_pc)});
        check_eq("pred_target", pred_target, exp_tgt);
`ifdef BTB_STATS_EN
        check_eq("stat_hits", stat_hits, m_hits);
        check_eq("stat_redirects", stat_redirects, m_redirs);
`else
        check_eq("stat_hits", stat_hits, 32'h0);
        check_eq("stat_redirects", stat_redirects, 32'h0);
`endif
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] rpc,
                        input bit uv, input logic [31:0] upc, input bit ut,
                        input logic [31:0] utgt);
        logic [31:0] nxt;
        int          ui;
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        @(posedge clk);
        if (r) begin
            m_pc = ResetPc;
            for (int i = 0; i < Entries; i++) m_valid[i] = 1'b0;
            m_hits   = 32'h0;
            m_redirs = 32'h0;
        end else begin
            if (rv)                nxt = rpc;
            else if (s)            nxt = m_pc;
            else if (m_pred(m_pc)) nxt = m_target[m_idx(m_pc)];
            else                   nxt = m_pc + 32'd4;
            if (m_hit(m_pc) && !s) m_hits = m_hits + 32'd1;
            if (rv)                m_redirs = m_redirs + 32'd1;
            if (uv) begin
                ui = m_idx(upc);
                if (m_hit(upc)) begin
                    if (ut) begin
                        m_ctr[ui]    = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
                        m_target[ui] = utgt;
                    end else begin
                        m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                    end
                end else if (ut) begin
                    m_valid[ui]  = 1'b1;
                    m_tag[ui]    = m_tagof(upc);
                    m_target[ui] = utgt;
                    m_ctr[ui]    = 2;
                end
            end
            m_pc = nxt;
        end
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic redir(input logic [31:0] a);
        step(0, 0, 1, a, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic upd(input logic [31:0] a, input bit t, input logic [31:0] tgt);
        step(0, 0, 0, 32'h0, 1, a, t, tgt);
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] upc;
        m_pc     = 32'h0;
        m_hits   = 32'h0;
        m_redirs = 32'h0;
        for (int i = 0; i < Entries; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 32'h0;
            m_target[i] = 32'h0;
            m_ctr[i]    = 0;
        end

        // Reset and sequential fetch.
        step(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        step(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_pred", {31'h0, pred_taken}, 32'h0);
        check_eq("rst_tgt", pred_target, 32'h0);
        idle(); check_eq("seq_pc4", pc, 32'h4);
        idle(); check_eq("seq_pc8", pc, 32'h8);
        idle(); check_eq("seq_pc12", pc, 32'hC);

        // Allocation then predicted-taken refetch of 0x10.
        upd(32'h10, 1, 32'h40);
        check_eq("alloc_pc", pc, 32'h10);
        check_eq("alloc_pred", {31'h0, pred_taken}, 32'h1);
        check_eq("alloc_tgt", pred_target, 32'h40);
        idle(); check_eq("follow_tgt", pc, 32'h40);

        // Counter 2 -> 0 -> 1: never predicted.
        upd(32'h10, 0, 32'h0);
        upd(32'h10, 0, 32'h0);
        redir(32'h10);
        check_eq("ctr0_pred", {31'h0, pred_taken}, 32'h0);
        idle(); check_eq("ctr0_next", pc, 32'h14);
        upd(32'h10, 1, 32'h40);
        redir(32'h10);
        check_eq("ctr1_pred", {31'h0, pred_taken}, 32'h0);

        // Redirect overrides stall.
        step(0, 1, 1, 32'h200, 0, 32'h0, 0, 32'h0);
        check_eq("stall_redir", pc, 32'h200);

        // Aliasing: 0x50 evicts 0x10 from the same index.
        upd(32'h10, 1, 32'h40);
        upd(32'h50, 1, 32'h80);
        redir(32'h10);
        check_eq("alias_old_pred", {31'h0, pred_taken}, 32'h0);
        check_eq("alias_old_tgt", pred_target, 32'h0);
        redir(32'h50);
        check_eq("alias_new_pred", {31'h0, pred_taken}, 32'h1);
        check_eq("alias_new_tgt", pred_target, 32'h80);

        // Mid-run reset with a concurrent update that must be dropped.
        redir(32'h80);
        check_eq("pre_rst_pc", pc, 32'h80);
        step(1, 0, 0, 32'h0, 1, 32'h80, 1, 32'h300);
        check_eq("mid_rst_pc", pc, ResetPc);
        check_eq("mid_rst_hits", stat_hits, 32'h0);
        check_eq("mid_rst_redirs", stat_redirects, 32'h0);
        redir(32'h50);
        check_eq("post_rst_50", {31'h0, pred_taken}, 32'h0);
        redir(32'h80);
        check_eq("post_rst_80", {31'h0, pred_taken}, 32'h0);

        // Address wrap.
        redir(32'hFFFF_FFFC);
        idle(); check_eq("wrap_pc", pc, 32'h0);

        // Random traffic over a small address space to force hits and aliasing.
        for (int n = 0; n < 3000; n++) begin
            rpc = (($urandom_range(0, 15) == 0) ? 32'hFFFF_FF00 : 32'h0)
                  | (32'($urandom_range(0, 63)) << 2);
            case ($urandom_range(0, 3))
                0:       upc = m_pc;
                1:       upc = 32'($urandom_range(0, 1023));
                default: upc = 32'($urandom_range(0, 63)) << 2;
            endcase
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, rpc,
                 $urandom_range(0, 1) == 1, upc, $urandom_range(0, 2) != 0,
                 32'($urandom_range(0, 63)) << 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
